sram_ctrl: RTL and testbench

//  Multi-cycle SRAM access sequencer, directly downstream of the CPU/SRAM data mux.

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sram_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the external 16-bit async SRAM sequencer.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACC   = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } sram_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Multi-cycle async SRAM access sequencer: one-shot CPU request in, timed active-low strobes out.
// Every output is a register loaded from the next-state decode, so strobes are glitch-free.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_in
);

  localparam int CNT_W = $clog2(max_int(RD_WAIT, WR_WAIT) + 1);

  if (RD_WAIT < 1) begin : g_bad_rd
    $error("sram_ctrl: RD_WAIT must be >= 1");
  end
  if (WR_WAIT < 1) begin : g_bad_wr
    $error("sram_ctrl: WR_WAIT must be >= 1");
  end

  sram_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic              vld_q, vld_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic              dq_oe_q, dq_oe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    vld_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = req_addr;
          be_d   = req_be;
          if (req_we) begin
            dout_d  = req_wdata;
            state_d = WR_SETUP;
          end else begin
            state_d = RD_ACC;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      RD_ACC: begin
        // Sample on the final cycle's edge while CE_N/OE_N are still asserted.
        if (cnt_q == '0) begin
          rdata_d = dq_in;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_W'(WR_WAIT - 1);
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_HOLD: begin
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode keyed on the state being entered, so the registered pins line up with it.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    rdy_d   = (state_d == IDLE);

    case (state_d)
      RD_ACC: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = ~be_d[1];
        lb_n_d = ~be_d[0];
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
      end
      WR_PULSE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign dq_out    = dout_q;
  assign dq_oe     = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a byte-lane SRAM model and a per-cycle strobe invariant monitor.
module tb_sram_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req, req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe;

  int n_vec  = 0;
  int n_miss = 0;
  int n_viol = 0;
  logic mon_en = 1'b0;

  logic [15:0] mem [0:255];

  always #5 Clk = ~Clk;

  sram_ctrl #(.ADDR_W(20), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  // SRAM: only driven data with CE/WE low lands in the selected byte lanes.
  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N && dq_oe) begin
      if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= dq_out[15:8];
      if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= dq_out[7:0];
    end
  end
  assign dq_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;

  logic        p_ce_n, p_ub_n, p_lb_n, p_dq_oe;
  logic [19:0] p_addr;
  always @(negedge Clk) begin
    if (mon_en) begin
      if (!SRAM_OE_N && dq_oe)                  n_viol++;
      if (!SRAM_OE_N && !SRAM_WE_N)             n_viol++;
      if (!SRAM_OE_N && p_dq_oe)                n_viol++;
      if (!SRAM_CE_N && !p_ce_n &&
          (SRAM_ADDR != p_addr || SRAM_UB_N != p_ub_n || SRAM_LB_N != p_lb_n)) n_viol++;
    end
    p_ce_n = SRAM_CE_N; p_ub_n = SRAM_UB_N; p_lb_n = SRAM_LB_N;
    p_dq_oe = dq_oe; p_addr = SRAM_ADDR;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue from a negedge; returns at the negedge of the rsp_valid cycle (lat = cycles after accept).
  task automatic access(input logic we, input logic [19:0] a, input logic [15:0] d,
                        input logic [1:0] be, output int lat, output int we_lo,
                        output int oe_lo, output int oe_en, output int ub_lo,
                        output int lb_lo, output int rdy_hi, output logic [19:0] a_seen);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(posedge Clk); #1;
    req = 1'b0; req_addr = '1; req_wdata = 16'h5555; req_be = 2'b11; req_we = ~we;
    lat = 99; we_lo = 0; oe_lo = 0; oe_en = 0; ub_lo = 0; lb_lo = 0; rdy_hi = 0; a_seen = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (rsp_valid) begin lat = n; break; end
      if (n == 1) a_seen = SRAM_ADDR;
      if (!SRAM_WE_N) we_lo++;
      if (!SRAM_OE_N) oe_lo++;
      if (dq_oe)      oe_en++;
      if (!SRAM_UB_N) ub_lo++;
      if (!SRAM_LB_N) lb_lo++;
      if (req_ready)  rdy_hi++;
    end
  endtask

  int lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi;
  logic [19:0] a_seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    Reset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    mon_en = 1'b1;

    access(1'b1, 20'h00123, 16'hBEEF, 2'b11, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("wr_lat", lat, 5);
    chk("wr_we_lo", we_lo, 2);
    chk("wr_dq_oe", oe_en, 4);
    chk("wr_oe_lo", oe_lo, 0);
    chk("wr_lanes", {ub_lo[7:0], lb_lo[7:0]}, 16'h0404);
    chk("wr_addr", a_seen, 20'h00123);
    chk("wr_ready", rdy_hi, 0);
    chk("wr_mem", mem[8'h23], 16'hBEEF);
    chk("wr_rdata_held", rsp_rdata, 0);
    @(negedge Clk);

    access(1'b0, 20'h00123, 16'h0000, 2'b11, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("rd_lat", lat, 3);
    chk("rd_oe_lo", oe_lo, 2);
    chk("rd_dq_oe", oe_en, 0);
    chk("rd_ready", rdy_hi, 0);
    chk("rd_data", rsp_rdata, 16'hBEEF);
    @(negedge Clk);
    chk("rd_valid_pulse", rsp_valid, 0);
    chk("rd_data_hold", rsp_rdata, 16'hBEEF);

    access(1'b1, 20'h00123, 16'h1234, 2'b01, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("wr01_lat", lat, 5);
    chk("wr01_ub_lo", ub_lo, 0);
    chk("wr01_lb_lo", lb_lo, 4);
    chk("wr01_rdata_held", rsp_rdata, 16'hBEEF);
    @(negedge Clk);
    access(1'b0, 20'h00123, 16'h0000, 2'b11, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("rd01_data", rsp_rdata, 16'hBE34);
    @(negedge Clk);

    access(1'b1, 20'h00123, 16'hFFFF, 2'b00, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("be00_lat", lat, 5);
    chk("be00_lanes", ub_lo + lb_lo, 0);
    chk("be00_mem", mem[8'h23], 16'hBE34);
    @(negedge Clk);

    access(1'b1, 20'hABC77, 16'hA5C3, 2'b11, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("b2b_wr_lat", lat, 5);
    chk("b2b_wr_addr", a_seen, 20'hABC77);
    chk("b2b_ready", req_ready, 1);
    access(1'b0, 20'hABC77, 16'h0000, 2'b11, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("b2b_rd_lat", lat, 3);
    chk("b2b_rd_data", rsp_rdata, 16'hA5C3);
    @(negedge Clk);

    req = 1'b1; req_we = 1'b1; req_addr = 20'h00050; req_wdata = 16'h7777; req_be = 2'b11;
    @(posedge Clk); #1;
    req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_in_pulse", SRAM_WE_N, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_strobes", {SRAM_WE_N, SRAM_CE_N, dq_oe}, 3'b110);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_valid_after", rsp_valid, 0);

    access(1'b0, 20'h00123, 16'h0000, 2'b11, lat, we_lo, oe_lo, oe_en, ub_lo, lb_lo, rdy_hi, a_seen);
    chk("rerun_lat", lat, 3);
    chk("rerun_oe_lo", oe_lo, 2);
    chk("rerun_data", rsp_rdata, 16'hBE34);
    @(negedge Clk);

    chk("invariants", n_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
